counter_ctrl_seq: RTL
=====================

# counter_ctrl_seq

Command sequencer that drives the control side of the up/down counter and checks its count output against an internal shadow model. It accepts CLEAR / LOAD / UP / DOWN commands over a valid/ready handshake and expands each into cycle-accurate Enable/Load/UpDown/Reset strobes. It reports command completion and any divergence between the counter's output and the predicted value. It sits between a test/stimulus controller and one counter instance.

## Interface
- WIDTH, 8, counter data width; also width of command data/count field
- Clk  in  1  rising-edge clock, shared with the counter
- Reset_n  in  1  asynchronous, active-low reset
- Cmd_Valid  in  1  command present
- Cmd_Ready  out  1  block can accept a command
- Cmd_Op  in  2  opcode, encoding from package
- Cmd_Data  in  WIDTH  LOAD value, or UP/DOWN step count
- Ctr_Reset  out  1  synchronous active-high reset to the counter
- Ctr_Enable  out  1  counter Enable
- Ctr_Load  out  1  counter Load
- Ctr_UpDown  out  1  counter direction, 1 = up
- Ctr_In_Data  out  WIDTH  counter load data
- Ctr_Out_Data  in  WIDTH  counter output
- Done  out  1  one-cycle pulse, command complete
- Err_Clr  in  1  clears Mismatch_Err and Err_Count
- Mismatch_Err  out  1  sticky compare failure
- Err_Count  out  8  saturating mismatch count

## Operation
- FSM states: IDLE, CLEAR, LOAD, STEP. Cmd_Ready = 1 only in IDLE.
- A command is accepted on a rising edge with Cmd_Valid && Cmd_Ready. Op and Data are latched.
- CLEAR: one drive cycle with Ctr_Reset = 1. Then back to IDLE.
- LOAD: one drive cycle with Ctr_Enable = 1, Ctr_Load = 1 and Ctr_In_Data = latched data. Then back to IDLE.
- UP / DOWN with count N ≥ 1:
  - N consecutive drive cycles with Ctr_Enable = 1, Ctr_Load = 0.
  - Ctr_UpDown = 1 for UP, 0 for DOWN.
  - A down-counter of remaining steps is held in STEP.
- UP / DOWN with N = 0: no drive cycles. FSM goes IDLE → STEP → IDLE with all strobes low. Done still pulses.
- Outside drive cycles, all Ctr_* strobes are 0. Ctr_In_Data holds its last value.
- Shadow register:
  - Updates at every edge using the counter's rules, from the strobes driven in that cycle.
  - Rule priority: Reset → 0, then Load → data, then Enable & UpDown → +1, then Enable & !UpDown → −1.
  - Arithmetic is modulo 2^WIDTH, so 255+1 = 0 and 0−1 = 255 for WIDTH = 8.
- Synced flag:
  - Set by the first completed CLEAR or LOAD.
  - Cleared only by Reset_n.
  - Before Synced, no compare is made.
- Compare: at each edge with Synced = 1, if Ctr_Out_Data ≠ shadow:
  - Mismatch_Err is set.
  - Err_Count increments, saturating at 255.
- Err_Clr has priority over a same-cycle mismatch. Both error outputs clear to 0.

## Timing
- Reset values: Cmd_Ready = 0 during reset and 1 from the first edge after release. All Ctr_* = 0, Done = 0, Mismatch_Err = 0, Err_Count = 0. Shadow = 0, Synced = 0, FSM = IDLE.
- Accept at edge k → drive cycles occupy k..k+N−1, with strobes registered so they are visible after edge k. Done is high in cycle k+N, when Cmd_Ready is also high again.
  - CLEAR and LOAD take N = 1.
  - N = 0 gives Done in cycle k+1.
- Back-to-back commands: a new command may be accepted on the edge that ends the Done cycle. No extra bubble is required.
- Compare window: the counter and the shadow both register on the same edge, so equal values are compared on every edge after Synced.
- Reset_n asserted mid-command: asynchronous return to reset values. The in-flight command is discarded and no Done is produced.
- Cmd_Valid while not ready: ignored. The source must hold Op and Data until accepted.

## Structure
- Package counter_ctrl_pkg holds:
  - cmd_op_e typedef: CMD_CLEAR = 2'b00, CMD_LOAD = 2'b01, CMD_UP = 2'b10, CMD_DOWN = 2'b11.
  - state_e typedef.
  - ERR_CNT_MAX = 8'hFF.
- Sub-module counter_shadow_model holds the shadow register and the compare/error logic. It takes the Ctr_* strobes, Ctr_Out_Data, Synced and Err_Clr as inputs.
- The top level contains the FSM, step counter and handshake.

## Test plan
- Reset_n low mid-STEP (UP 100, reset after 40 steps) → all outputs at reset values immediately, no Done. After release, UP 1 with no prior CLEAR/LOAD → Mismatch_Err stays 0 because Synced = 0.
- CLEAR, then UP 5 → Ctr_Enable high for exactly 5 cycles, Done on the 6th cycle after accept. Counter reads 5, Mismatch_Err = 0.
- LOAD 8'hFE, then UP 3 → counter wraps FE, FF, 00, 01. DOWN 2 → FF. No mismatch.
- UP 0 → no strobes, Done one cycle after accept, count unchanged.
- Counter forced to a wrong value for 3 cycles after LOAD 8'h10 → Mismatch_Err = 1 and Err_Count = 3. Err_Clr → both 0.
- Cmd_Valid held with back-to-back LOAD 8'h20, DOWN 1 → second command accepted on the edge ending the first Done. Counter reads 8'h1F.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter command sequencer and its shadow checker.
package counter_ctrl_pkg;

    localparam int unsigned ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_UP    = 2'b10,
        CMD_DOWN  = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_LOAD  = 2'b10,
        ST_STEP  = 2'b11
    } state_e;

    // Control strobes presented to the counter in one cycle.
    typedef struct packed {
        logic rst;
        logic en;
        logic ld;
        logic up;
    } ctr_strobe_t;

endpackage

// File: rtl/counter_shadow_model.sv
// Shadow copy of the counter, updated from the driven strobes, with sticky compare error tracking.
module counter_shadow_model
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  ctr_strobe_t      strobe,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] out_data,
    input  logic             synced,
    input  logic             err_clr,
    output logic             mismatch_err,
    output logic [ERR_W-1:0] err_count
);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             mismatch_c;

    // Counter behaviour: reset over load over count, modulo 2^WIDTH.
    always_comb begin
        shadow_d = shadow_q;
        if (strobe.rst) begin
            shadow_d = '0;
        end else if (strobe.ld) begin
            shadow_d = in_data;
        end else if (strobe.en && strobe.up) begin
            shadow_d = shadow_q + WIDTH'(1);
        end else if (strobe.en) begin
            shadow_d = shadow_q - WIDTH'(1);
        end
    end

    assign mismatch_c = synced && (out_data != shadow_q);

    // A clear request wins over a mismatch seen on the same edge.
    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (err_clr) begin
            err_d = 1'b0;
            cnt_d = '0;
        end else if (mismatch_c) begin
            err_d = 1'b1;
            if (cnt_q != ERR_CNT_MAX) begin
                cnt_d = cnt_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mismatch_err = err_q;
    assign err_count    = cnt_q;

endmodule

// File: rtl/counter_ctrl_seq.sv
// Command sequencer: expands CLEAR/LOAD/UP/DOWN commands into registered counter strobes
// and checks the counter output against a shadow model.
module counter_ctrl_seq
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Cmd_Valid,
    output logic             Cmd_Ready,
    input  logic [1:0]       Cmd_Op,
    input  logic [WIDTH-1:0] Cmd_Data,
    output logic             Ctr_Reset,
    output logic             Ctr_Enable,
    output logic             Ctr_Load,
    output logic             Ctr_UpDown,
    output logic [WIDTH-1:0] Ctr_In_Data,
    input  logic [WIDTH-1:0] Ctr_Out_Data,
    output logic             Done,
    input  logic             Err_Clr,
    output logic             Mismatch_Err,
    output logic [ERR_W-1:0] Err_Count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic             up_q, up_d;
    logic [WIDTH-1:0] data_q, data_d;
    ctr_strobe_t      strobe_q, strobe_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             synced_q, synced_d;
    logic             accept_c;
    cmd_op_e          op_c;

    assign accept_c = Cmd_Valid && ready_q;
    assign op_c     = cmd_op_e'(Cmd_Op);

    // Strobes are computed for the cycle being entered, so they appear right after the accept edge.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        up_d     = up_q;
        data_d   = data_q;
        strobe_d = '0;
        done_d   = 1'b0;
        synced_d = synced_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    case (op_c)
                        CMD_CLEAR: begin
                            state_d      = ST_CLEAR;
                            strobe_d.rst = 1'b1;
                        end
                        CMD_LOAD: begin
                            state_d     = ST_LOAD;
                            data_d      = Cmd_Data;
                            strobe_d.en = 1'b1;
                            strobe_d.ld = 1'b1;
                        end
                        default: begin
                            state_d     = ST_STEP;
                            step_d      = Cmd_Data;
                            up_d        = (op_c == CMD_UP);
                            strobe_d.en = (Cmd_Data != '0);
                            strobe_d.up = (op_c == CMD_UP) && (Cmd_Data != '0);
                        end
                    endcase
                end
            end
            ST_CLEAR, ST_LOAD: begin
                state_d  = ST_IDLE;
                done_d   = 1'b1;
                synced_d = 1'b1;
            end
            ST_STEP: begin
                // step_q counts drive cycles left including the current one; zero means none.
                if (step_q <= WIDTH'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    step_d      = step_q - WIDTH'(1);
                    strobe_d.en = 1'b1;
                    strobe_d.up = up_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            up_q     <= 1'b0;
            data_q   <= '0;
            strobe_q <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            synced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            up_q     <= up_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            synced_q <= synced_d;
        end
    end

    assign Cmd_Ready   = ready_q;
    assign Ctr_Reset   = strobe_q.rst;
    assign Ctr_Enable  = strobe_q.en;
    assign Ctr_Load    = strobe_q.ld;
    assign Ctr_UpDown  = strobe_q.up;
    assign Ctr_In_Data = data_q;
    assign Done        = done_q;

    counter_shadow_model #(
        .WIDTH(WIDTH)
    ) u_shadow (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .strobe      (strobe_q),
        .in_data     (data_q),
        .out_data    (Ctr_Out_Data),
        .synced      (synced_q),
        .err_clr     (Err_Clr),
        .mismatch_err(Mismatch_Err),
        .err_count   (Err_Count)
    );

endmodule
